// File: rtl/dmem_pkg.sv
// Shared types and constants for the dmem_resp data-memory responder.
// Holds the FSM state encoding, default geometry/latency, zero data word.
package dmem_pkg;

    // Default byte-address width: 9 bits -> 128 words of 32 bits.
    localparam int AW_DEF = 9;

    // Default number of wait states between accept and array access.
    localparam int WAIT_CYC_DEF = 2;

    // Data word returned for writes, errors and idle.
    localparam logic [31:0] ZERO_DATA = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_e;

    // Word accesses only: any nonzero byte offset is an error.
    function automatic logic is_misaligned(input logic [1:0] byte_off);
        return |byte_off;
    endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word array: synchronous write, synchronous read, no reset.
// Ports: clk; we/re strobes; addr word index; wdata in; rdata registered.
module dmem_ram #(
    parameter int WA = 7
) (
    input  logic          clk,
    input  logic          we,
    input  logic          re,
    input  logic [WA-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [0:(1<<WA)-1];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_resp.sv
// Data-memory responder: valid/ready request and response channels,
// programmable wait states, one outstanding access, misalignment error.
// Ports: clk, rst (async high); req_valid/ready/we/addr/wdata;
//        rsp_valid/ready/rdata/err. All outputs come straight from flops.
module dmem_resp
    import dmem_pkg::*;
#(
    parameter int AW       = AW_DEF,
    parameter int WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [AW-1:0] req_addr,
    input  logic [31:0]   req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [31:0]   rsp_rdata,
    output logic          rsp_err
);

    localparam int WA = AW - 2;

    // Counter load value; WAIT is skipped entirely when WAIT_CYC is 0.
    localparam logic [3:0] WAIT_LD =
        (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

    state_e        state_q, state_d;
    logic [3:0]    cnt_q, cnt_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic          req_ready_q, req_ready_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [31:0]   rsp_rdata_q, rsp_rdata_d;
    logic          rsp_err_q, rsp_err_d;

    logic          misal;
    logic          ram_we;
    logic          ram_re;
    logic [31:0]   ram_rdata;

    assign misal = is_misaligned(addr_q[1:0]);

    // Gate with rst so an edge coincident with reset never commits.
    assign ram_we = (state_q == ST_ACCESS) & we_q & ~misal & ~rst;
    assign ram_re = (state_q == ST_ACCESS) & ~we_q & ~misal;

    dmem_ram #(
        .WA(WA)
    ) u_ram (
        .clk  (clk),
        .we   (ram_we),
        .re   (ram_re),
        .addr (addr_q[AW-1:2]),
        .wdata(wdata_q),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req_valid && req_ready_q) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    if (WAIT_CYC == 0) begin
                        state_d = ST_ACCESS;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_LD;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = ST_ACCESS;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_ACCESS: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // First RESP cycle captures the array's registered read
                // data; the response is presented from the next edge on.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = misal;
                    rsp_rdata_d = (we_q || misal) ? ZERO_DATA : ram_rdata;
                end else if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = ZERO_DATA;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        req_ready_d = (state_d == ST_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= ZERO_DATA;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= ZERO_DATA;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule
